// File: rtl/serial_tx_frame_pkg.sv
// Shared definitions for the framed serial link: frame state encoding and
// parity-mode constants, used by the transmitter and the future receiver.
package serial_tx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Any parity setting outside even/odd collapses to "no parity bit".
    function automatic int par_mode(input int parity);
        if (parity == PAR_EVEN || parity == PAR_ODD) begin
            return parity;
        end
        return PAR_NONE;
    endfunction

endpackage

// File: rtl/serial_tx_frame_baud_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at zero while clr is high so every frame starts a
// fresh bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps at the end of each bit period, cleared while idle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx_frame.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit, stop bit. Line idles high.
//
//   state | meaning
//   IDLE  | line high, ready for a word
//   START | line low for one bit period
//   DATA  | shifting data bits out, LSB first
//   PAR   | parity bit of the captured word
//   STOP  | line high for one bit period, done on its last cycle
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    import serial_tx_frame_pkg::*;

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam int PAR_MODE = par_mode(PARITY);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic              par_bit, par_nxt;
    logic              sout_nxt;
    logic              baud_clr;
    logic              tick;

    assign baud_clr = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Next-state, datapath update and next line value. The line is driven
    // from a flop, so its value is derived from the next-state signals.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        par_nxt   = par_bit;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = START;
                    shift_nxt = din;
                    bit_nxt   = '0;
                    par_nxt   = (^din) ^ (PAR_MODE == PAR_ODD);
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt   = '0;
                        state_nxt = (PAR_MODE != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   sout_nxt = 1'b0;
            DATA:    sout_nxt = shift_nxt[0];
            PAR:     sout_nxt = par_nxt;
            default: sout_nxt = 1'b1;
        endcase
    end

    // State, datapath and line registers; the line is set high on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            sout      <= 1'b1;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_nxt;
            par_bit   <= par_nxt;
            sout      <= sout_nxt;
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign done  = (state == STOP) && tick;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: four instances cover no parity, even,
// odd, and a one-cycle-per-bit 4-bit configuration.
module tb_serial_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_v [4];
    logic [3:0] load_v;
    logic [3:0] sout_v, ready_v, busy_v, done_v;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0)) u_a (
        .clk(clk), .rst(rst), .din(din_v[0]), .load(load_v[0]),
        .ready(ready_v[0]), .sout(sout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1)) u_b (
        .clk(clk), .rst(rst), .din(din_v[1]), .load(load_v[1]),
        .ready(ready_v[1]), .sout(sout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2)) u_c (
        .clk(clk), .rst(rst), .din(din_v[2]), .load(load_v[2]),
        .ready(ready_v[2]), .sout(sout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    serial_tx_frame #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY(0)) u_d (
        .clk(clk), .rst(rst), .din(din_v[3][3:0]), .load(load_v[3]),
        .ready(ready_v[3]), .sout(sout_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    // Check idle outputs for n consecutive cycles.
    task automatic idle_chk(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_sout",  i, sout_v[inst],  1'b1);
            chk("idle_ready", i, ready_v[inst], 1'b1);
            chk("idle_busy",  i, busy_v[inst],  1'b0);
            chk("idle_done",  i, done_v[inst],  1'b0);
        end
    endtask

    // Present a word for one accept edge, then release load.
    task automatic send(input int inst, input logic [7:0] d);
        @(negedge clk);
        din_v[inst]  = d;
        load_v[inst] = 1'b1;
        @(posedge clk);
        #1 load_v[inst] = 1'b0;
    endtask

    // Called just after the accept edge. bits[i] is the i-th bit on the line.
    // inj_kind: 0 none, 1 pulse load with 8'h3C at cycle inj_at, 2 reset at inj_at.
    task automatic check_frame(input int inst, input logic [15:0] bits, input int nbits,
                               input int cpb, input int inj_kind, input int inj_at);
        int len;
        len = nbits * cpb;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk("sout",  k, sout_v[inst],  bits[(k - 1) / cpb]);
            chk("done",  k, done_v[inst],  k == len);
            chk("ready", k, ready_v[inst], 1'b0);
            chk("busy",  k, busy_v[inst],  1'b1);
            if (inj_kind == 1 && k == inj_at) begin
                din_v[inst]  = 8'h3C;
                load_v[inst] = 1'b1;
            end
            if (inj_kind == 1 && k == inj_at + 1) begin
                load_v[inst] = 1'b0;
            end
            if (inj_kind == 2 && k == inj_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_sout",  k, sout_v[inst],  1'b1);
                chk("rst_ready", k, ready_v[inst], 1'b1);
                chk("rst_busy",  k, busy_v[inst],  1'b0);
                chk("rst_done",  k, done_v[inst],  1'b0);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        load_v = '0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_sout",  i, sout_v[i],  1'b1);
            chk("reset_ready", i, ready_v[i], 1'b1);
            chk("reset_busy",  i, busy_v[i],  1'b0);
            chk("reset_done",  i, done_v[i],  1'b0);
        end
        rst = 1'b0;

        // A5, no parity: 0 | 1,0,1,0,0,1,0,1 | 1
        send(0, 8'hA5);
        check_frame(0, 16'(10'b11_0100_1010), 10, 4, 0, 0);
        idle_chk(0, 2);

        // A5, even parity -> parity bit 0
        send(1, 8'hA5);
        check_frame(1, 16'(11'b101_0100_1010), 11, 4, 0, 0);
        idle_chk(1, 2);

        // A5, odd parity -> parity bit 1
        send(2, 8'hA5);
        check_frame(2, 16'(11'b111_0100_1010), 11, 4, 0, 0);
        idle_chk(2, 2);

        // Back-to-back: 00 then FF with load held; din changes after accept.
        @(negedge clk);
        din_v[0]  = 8'h00;
        load_v[0] = 1'b1;
        @(posedge clk);
        #1 din_v[0] = 8'hFF;
        check_frame(0, 16'(10'h200), 10, 4, 0, 0);
        @(negedge clk);
        chk("b2b_gap_sout",  0, sout_v[0],  1'b1);
        chk("b2b_gap_ready", 0, ready_v[0], 1'b1);
        chk("b2b_gap_busy",  0, busy_v[0],  1'b0);
        check_frame(0, 16'(10'h3FE), 10, 4, 0, 0);
        load_v[0] = 1'b0;
        idle_chk(0, 3);

        // Load pulsed mid DATA bit 3 is ignored; no extra frame follows.
        send(0, 8'hA5);
        check_frame(0, 16'(10'b11_0100_1010), 10, 4, 1, 18);
        idle_chk(0, 12);

        // Reset during DATA bit 5 of 5A, then a clean 81 frame.
        send(0, 8'h5A);
        check_frame(0, 16'(10'h2B4), 10, 4, 2, 26);
        send(0, 8'h81);
        check_frame(0, 16'(10'h302), 10, 4, 0, 0);
        idle_chk(0, 2);

        // Reset and load in the same cycle: reset wins, word not taken.
        @(negedge clk);
        rst       = 1'b1;
        din_v[0]  = 8'hFF;
        load_v[0] = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        load_v[0] = 1'b0;
        chk("rst_load_ready", 0, ready_v[0], 1'b1);
        chk("rst_load_busy",  0, busy_v[0],  1'b0);
        idle_chk(0, 2);

        // One cycle per bit, 4-bit word 1101: 0,1,0,1,1,1
        send(3, 8'h0D);
        check_frame(3, 16'(6'b111010), 6, 1, 0, 0);
        idle_chk(3, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
